// File: rtl/audio_sample_scheduler_if.sv
// Stereo sample source handshake: valid/ready transfer of one {left, right} pair.
// Latency: none, this only bundles wires.
// Backpressure: the scheduler drives src_ready; a transfer happens when src_valid & src_ready.
// Ports: src_valid/src_sample are driven by the source (master); src_ready by the scheduler (slave).
interface audio_sample_scheduler_if #(
    parameter int W = 16
) ();
    logic             src_valid;
    logic             src_ready;
    logic [2*W-1:0]   src_sample;

    modport master (output src_valid, output src_sample, input src_ready);
    modport slave  (input src_valid, input src_sample, output src_ready);
endinterface

// File: rtl/audio_sample_scheduler.sv
// Audio sample pacer: fractional accumulator turns clk_pixel into an exact-average sample strobe and pops a small FIFO.
// Latency: clk_audio and audio_sample_word change on the edge after the strobe decision; FIFO push-to-pop is at least one cycle.
// Backpressure: src_ready drops while the FIFO holds FIFO_DEPTH entries; popping on a strobe frees a slot for the next cycle.
// Ports: clk_pixel/reset_n (sole clock, async active-low reset); cfg_load/cfg_pixel_hz/cfg_sample_hz
//        reconfigure the rate, cfg_error flags an invalid pair; src is the source handshake; clk_audio is the
//        1-cycle strobe, audio_sample_word the held pair, underrun a sticky empty-on-strobe flag, fifo_level the fill.
module audio_sample_scheduler #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int DEF_PIXEL_HZ    = 40_000_000,
    parameter int DEF_SAMPLE_HZ   = 48_000
) (
    input  logic                             clk_pixel,
    input  logic                             reset_n,
    input  logic                             cfg_load,
    input  logic [27:0]                      cfg_pixel_hz,
    input  logic [16:0]                      cfg_sample_hz,
    output logic                             cfg_error,
    audio_sample_scheduler_if.slave          src,
    output logic                             clk_audio,
    output logic [2*AUDIO_BIT_WIDTH-1:0]     audio_sample_word,
    output logic                             underrun,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DW    = 2 * AUDIO_BIT_WIDTH;

    localparam logic [27:0]      DEF_PIX  = 28'(DEF_PIXEL_HZ);
    localparam logic [16:0]      DEF_SMP  = 17'(DEF_SAMPLE_HZ);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // Configuration and accumulator
    logic [27:0] pixel_hz_q, pixel_hz_d;
    logic [16:0] sample_hz_q, sample_hz_d;
    logic [27:0] acc_q, acc_d;
    logic        cfg_error_q, cfg_error_d;

    // Output registers
    logic          clk_audio_q, clk_audio_d;
    logic [DW-1:0] word_q, word_d;
    logic          underrun_q, underrun_d;

    // FIFO bookkeeping
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [DW-1:0]    mem_q [FIFO_DEPTH];

    // Holds src_ready low until the first edge after reset release.
    logic ready_en_q;

    logic [28:0] sum;
    logic        wrap;
    logic        strobe;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    // acc < pixel_hz and sample_hz < pixel_hz in a valid config, so sum < 2*pixel_hz
    // and the wrapped value always fits back into 28 bits.
    assign sum        = {1'b0, acc_q} + {12'd0, sample_hz_q};
    assign wrap       = (sum >= {1'b0, pixel_hz_q});
    // A cfg_load in the same cycle wins: the pending strobe is dropped.
    assign strobe     = wrap & ~cfg_error_q & ~cfg_load;
    assign fifo_empty = (level_q == '0);

    assign src.src_ready = ready_en_q & (level_q != LVL_FULL);

    // The flush on cfg_load also discards a push landing in that same cycle.
    assign push = src.src_valid & src.src_ready & ~cfg_load;
    assign pop  = strobe & ~fifo_empty;

    always_comb begin
        pixel_hz_d  = pixel_hz_q;
        sample_hz_d = sample_hz_q;
        acc_d       = acc_q;
        cfg_error_d = cfg_error_q;
        clk_audio_d = strobe;
        word_d      = word_q;
        underrun_d  = underrun_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;

        if (cfg_load) begin
            pixel_hz_d  = cfg_pixel_hz;
            sample_hz_d = cfg_sample_hz;
            acc_d       = '0;
            cfg_error_d = (cfg_pixel_hz == '0) | (cfg_sample_hz == '0) |
                          ({11'd0, cfg_sample_hz} >= cfg_pixel_hz);
            underrun_d  = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
        end else begin
            // The accumulator is frozen while the config is invalid; only a
            // new cfg_load can leave that state and it clears acc anyway.
            if (!cfg_error_q) begin
                acc_d = wrap ? 28'(sum - {1'b0, pixel_hz_q}) : sum[27:0];
            end

            if (strobe && fifo_empty) begin
                underrun_d = 1'b1;
            end

            if (pop) begin
                word_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end

            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            pixel_hz_q  <= DEF_PIX;
            sample_hz_q <= DEF_SMP;
            acc_q       <= '0;
            cfg_error_q <= 1'b0;
            clk_audio_q <= 1'b0;
            word_q      <= '0;
            underrun_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            pixel_hz_q  <= pixel_hz_d;
            sample_hz_q <= sample_hz_d;
            acc_q       <= acc_d;
            cfg_error_q <= cfg_error_d;
            clk_audio_q <= clk_audio_d;
            word_q      <= word_d;
            underrun_q  <= underrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ready_en_q  <= 1'b1;
        end
    end

    // Storage needs no reset: level and pointers decide what is readable.
    always_ff @(posedge clk_pixel) begin
        if (push) begin
            mem_q[wr_ptr_q] <= src.src_sample;
        end
    end

    assign cfg_error         = cfg_error_q;
    assign clk_audio         = clk_audio_q;
    assign audio_sample_word = word_q;
    assign underrun          = underrun_q;
    assign fifo_level        = level_q;
endmodule
